// File: rtl/poci_transmitter_if.sv
// POCI register-read bus: address request and read-mux handshake from the receive side,
// plus the serial output and framing strobes of the transmitter.
interface poci_transmitter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] start_addr;
    logic              addr_valid;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] read_addr;
    logic              serial_out;
    logic              tx_active;
    logic              byte_done;

    // The master side owns the address request and the register read mux.
    modport master (
        output start_addr, addr_valid, read_data,
        input  read_addr, serial_out, tx_active, byte_done
    );

    modport slave (
        input  start_addr, addr_valid, read_data,
        output read_addr, serial_out, tx_active, byte_done
    );
endinterface

// File: rtl/poci_transmitter.sv
// POCI transmitter: reads registers through an external read mux and shifts each byte out
// MSB-first on sclk, auto-incrementing the address while addr_valid stays high.
module poci_transmitter #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF
) (
    input logic                 sclk,
    input logic                 rstn,
    poci_transmitter_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              serial_out_q, serial_out_d;
    logic              tx_active_q, tx_active_d;
    logic              byte_done_q, byte_done_d;
    logic              load;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : ADDR_W'(a + 1'b1);
    endfunction

    // NOTE: every variable gets its default before the case so no path can leave it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        read_addr_d  = read_addr_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        serial_out_d = serial_out_q;
        tx_active_d  = tx_active_q;
        byte_done_d  = 1'b0;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                serial_out_d = 1'b0;
                if (bus.addr_valid) begin
                    read_addr_d = bus.start_addr;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    serial_out_d = shift_q[DATA_W-1];
                    shift_d      = {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d    = bit_cnt_q - 1'b1;
                end else begin
                    // Last bit has been on the line a full cycle: chain the next byte or stop.
                    byte_done_d = 1'b1;
                    if (bus.addr_valid) begin
                        load = 1'b1;
                    end else begin
                        serial_out_d = 1'b0;
                        tx_active_d  = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load action: commit the byte from the read mux and advance the pointer.
        if (load) begin
            serial_out_d = bus.read_data[DATA_W-1];
            shift_d      = {bus.read_data[DATA_W-2:0], 1'b0};
            bit_cnt_d    = CNT_W'(DATA_W - 1);
            tx_active_d  = 1'b1;
            read_addr_d  = next_addr(read_addr_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            read_addr_q  <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            serial_out_q <= 1'b0;
            tx_active_q  <= 1'b0;
            byte_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_addr_q  <= read_addr_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_out_q <= serial_out_d;
            tx_active_q  <= tx_active_d;
            byte_done_q  <= byte_done_d;
        end
    end

    assign bus.read_addr  = read_addr_q;
    assign bus.serial_out = serial_out_q;
    assign bus.tx_active  = tx_active_q;
    assign bus.byte_done  = byte_done_q;
endmodule

// File: tb/tb_poci_transmitter.sv
// Bench for poci_transmitter: directed streams push expected bits into a scoreboard queue,
// a negedge monitor pops and compares every bit the DUT shifts out.
module tb_poci_transmitter;
    logic sclk = 1'b0;
    logic rstn = 1'b1;

    poci_transmitter_if bus ();

    poci_transmitter dut (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;

    logic [7:0] regs [256];
    assign bus.read_data = regs[bus.read_addr];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int act_cnt  = 0;
    bit exp_q [$];
    bit mon_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    // Scoreboard monitor: every active cycle consumes one expected bit.
    always @(negedge sclk) begin
        if (rstn === 1'b1) begin
            if (bus.byte_done === 1'b1) done_cnt++;
            if (bus.tx_active === 1'b1) begin
                act_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_bit: got serial_out=%0b with no expected bit at %0t",
                             bus.serial_out, $time);
                end else begin
                    mon_bit = exp_q.pop_front();
                    check("serial_bit", {31'd0, bus.serial_out}, {31'd0, mon_bit});
                end
            end else begin
                check("idle_serial_out", {31'd0, bus.serial_out}, 32'd0);
            end
        end
    end

    // Request a stream at the next edge (edge N) and check the pointer latch.
    task automatic start_stream(input logic [7:0] addr);
        done_cnt = 0;
        act_cnt  = 0;
        @(negedge sclk);
        bus.start_addr = addr;
        bus.addr_valid = 1'b1;
        @(posedge sclk);
        #1;
        check("read_addr_latch", {24'd0, bus.read_addr}, {24'd0, addr});
        check("tx_active_at_idle_exit", {31'd0, bus.tx_active}, 32'd0);
    endtask

    // Bounded wait for the final byte_done, then verify the stream wrap-up.
    task automatic finish_stream(input int nbytes, input logic [7:0] final_addr);
        bit found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge sclk);
            if (bus.byte_done === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL byte_done_timeout: got no byte_done within 64 cycles required one");
        end
        check("tx_active_at_end", {31'd0, bus.tx_active}, 32'd0);
        @(posedge sclk);
        #1;
        check("byte_done_one_cycle", {31'd0, bus.byte_done}, 32'd0);
        check("byte_done_count", done_cnt, nbytes);
        check("tx_active_cycles", act_cnt, 8 * nbytes);
        check("scoreboard_empty", exp_q.size(), 0);
        check("read_addr_final", {24'd0, bus.read_addr}, {24'd0, final_addr});
    endtask

    // Hold addr_valid for nbytes, change start_addr mid-first-byte, drop during the last byte.
    task automatic run_stream(input logic [7:0] addr, input logic [7:0] mid_addr,
                              input int nbytes, input logic [7:0] final_addr);
        start_stream(addr);
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        bus.start_addr = mid_addr;
        repeat (8 * nbytes - 7) @(posedge sclk);
        @(negedge sclk);
        bus.addr_valid = 1'b0;
        finish_stream(nbytes, final_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h05] = 8'hA5;
        regs[8'h10] = 8'h3C;
        regs[8'h11] = 8'hFF;
        regs[8'h12] = 8'h00;
        regs[8'hFE] = 8'h81;
        regs[8'hFF] = 8'h7E;
        regs[8'h00] = 8'hC6;
        regs[8'h30] = 8'hB7;
        regs[8'h20] = 8'h12;
        regs[8'h21] = 8'h34;
        regs[8'h40] = 8'hEE;

        bus.start_addr = 8'h00;
        bus.addr_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        check("reset_serial_out", {31'd0, bus.serial_out}, 32'd0);
        check("reset_tx_active", {31'd0, bus.tx_active}, 32'd0);
        check("reset_read_addr", {24'd0, bus.read_addr}, 32'd0);
        repeat (2) @(negedge sclk);
        rstn = 1'b1;

        // Async reset in the middle of a byte clears everything without a clock edge.
        push_byte(8'hFF);
        start_stream(8'h11);
        repeat (5) @(posedge sclk);
        #2;
        check("pre_reset_tx_active", {31'd0, bus.tx_active}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midbyte_reset_serial_out", {31'd0, bus.serial_out}, 32'd0);
        check("midbyte_reset_tx_active", {31'd0, bus.tx_active}, 32'd0);
        check("midbyte_reset_byte_done", {31'd0, bus.byte_done}, 32'd0);
        check("midbyte_reset_read_addr", {24'd0, bus.read_addr}, 32'd0);
        bus.addr_valid = 1'b0;
        exp_q.delete();
        @(negedge sclk);
        rstn = 1'b1;
        repeat (2) @(negedge sclk);

        // Single byte with addr_valid high for exactly one edge; MSB appears after the LOAD edge.
        push_byte(8'hA5);
        start_stream(8'h05);
        @(negedge sclk);
        bus.addr_valid = 1'b0;
        @(posedge sclk);
        #1;
        check("load_edge_tx_active", {31'd0, bus.tx_active}, 32'd1);
        check("load_edge_msb", {31'd0, bus.serial_out}, 32'd1);
        check("load_edge_read_addr", {24'd0, bus.read_addr}, 32'h06);
        finish_stream(1, 8'h06);

        // Contiguous three-byte burst.
        push_byte(8'h3C);
        push_byte(8'hFF);
        push_byte(8'h00);
        run_stream(8'h10, 8'h10, 3, 8'h13);

        // Pointer wraps from 0xFF to 0x00.
        push_byte(8'h81);
        push_byte(8'h7E);
        push_byte(8'hC6);
        run_stream(8'hFE, 8'hFE, 3, 8'h01);

        // Early stop: addr_valid drops mid-byte, the byte still completes.
        push_byte(8'hB7);
        run_stream(8'h30, 8'h30, 1, 8'h31);

        // A new start_addr during SHIFT is ignored; the stream continues from 0x21.
        push_byte(8'h12);
        push_byte(8'h34);
        run_stream(8'h20, 8'h40, 2, 8'h22);

        repeat (3) @(negedge sclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
